mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/b16_bus_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/b16_bus_pkg.sv
// Shared bus definitions for the b16 memory subsystem: arbiter state
// encoding, bus width and byte-lane strobe encoding.
package b16_bus_pkg;

  // Bus ownership state of the memory arbiter
  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_DMA   = 2'd1,
    S_YIELD = 2'd2
  } arb_state_t;

  // Data/address width of the b16 bus
  localparam int unsigned L_BUS = 16;

  // Byte-lane strobe encoding: bit 1 = high byte, bit 0 = low byte
  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_BOTH = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Memory port arbiter between the CPU and a DMA requester.
// The CPU owns the bus by default. A DMA request takes the bus on the next
// cycle; after holdmax consecutive DMA cycles one CPU cycle is forced, but
// only while the CPU is enabled to run.
//
// Ports:
//   clk, reset                         clock, async active-low reset
//   run_en                             CPU run enable from the debugger
//   cpu_addr/cpu_rd/cpu_wr/cpu_wdata   CPU access request
//   cpu_rdata, cpu_run                 read data and run enable to the CPU
//   dma_req/dma_addr/dma_we/dma_wdata  DMA access request (level)
//   dma_ack, dma_rdata                 DMA access done this cycle, read data
//   mem_addr/mem_rd/mem_wr/mem_wdata   memory access port
//   mem_rdata                          memory read data (combinational)
module mem_arbiter
  import b16_bus_pkg::*;
#(
  parameter int unsigned l       = L_BUS,
  parameter int unsigned holdmax = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run_en,
  input  logic [l-1:0] cpu_addr,
  input  logic         cpu_rd,
  input  logic [1:0]   cpu_wr,
  input  logic [l-1:0] cpu_wdata,
  output logic [l-1:0] cpu_rdata,
  output logic         cpu_run,
  input  logic         dma_req,
  input  logic [l-1:0] dma_addr,
  input  logic [1:0]   dma_we,
  input  logic [l-1:0] dma_wdata,
  output logic         dma_ack,
  output logic [l-1:0] dma_rdata,
  output logic [l-1:0] mem_addr,
  output logic         mem_rd,
  output logic [1:0]   mem_wr,
  output logic [l-1:0] mem_wdata,
  input  logic [l-1:0] mem_rdata
);

  localparam int unsigned CW = (holdmax > 1) ? $clog2(holdmax) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(holdmax - 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic          dma_own;

  // Ownership FSM and consecutive-DMA-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CPU;
      cnt   <= '0;
    end else begin
      case (state)
        S_DMA: begin
          if (!dma_req)
            state <= S_CPU;
          else if (run_en && (cnt == CNT_MAX))
            state <= S_YIELD;
          else
            state <= S_DMA;
        end
        default: state <= dma_req ? S_DMA : S_CPU;
      endcase

      // Saturates so a debugger-halted CPU lets DMA hold the bus indefinitely
      if (state == S_DMA)
        cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      else
        cnt <= '0;
    end
  end

  // The registered state alone picks this cycle's owner
  assign dma_own = (state == S_DMA);

  // Address/data mux; DMA strobes are gated by dma_req so a dropped
  // request yields an idle cycle rather than a stale access
  assign mem_addr  = dma_own ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_own ? dma_wdata : cpu_wdata;
  assign mem_rd    = dma_own ? (dma_req && (dma_we == LANE_NONE)) : cpu_rd;
  assign mem_wr    = dma_own ? (dma_we & {2{dma_req}}) : cpu_wr;

  assign dma_ack   = dma_own & dma_req;
  assign dma_rdata = dma_ack ? mem_rdata : '0;
  assign cpu_rdata = mem_rdata;
  assign cpu_run   = run_en & ~dma_own;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-lane memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic [1:0]  cpu_wr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_run;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [1:0]  dma_we;
  logic [15:0] dma_wdata;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [1:0]  mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:65535];

  int tests = 0;
  int fails = 0;
  int acks;

  always #5 clk = ~clk;

  // Byte-lane write memory, combinational read
  always @(posedge clk) begin
    if (mem_wr[0]) mem[mem_addr][7:0]  <= mem_wdata[7:0];
    if (mem_wr[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
  end
  assign mem_rdata = mem[mem_addr];

  mem_arbiter #(.l(16), .holdmax(4)) dut (
    .clk(clk), .reset(reset), .run_en(run_en),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_run(cpu_run),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle boundary (inputs change at negedge)
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    bit exp_pat [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};

    reset = 1'b0; run_en = 1'b1;
    cpu_addr = 16'h0000; cpu_rd = 1'b0; cpu_wr = 2'b00; cpu_wdata = 16'h0000;
    dma_req = 1'b0; dma_addr = 16'h0000; dma_we = 2'b00; dma_wdata = 16'h0000;

    // Reset state, with a DMA request already pending
    next_cycle();
    dma_req = 1'b1; dma_addr = 16'h1234; cpu_addr = 16'h0042;
    #1;
    check("rst_ack", 16'(dma_ack), 16'h0);
    check("rst_run", 16'(cpu_run), 16'h1);
    check("rst_addr", mem_addr, 16'h0042);
    run_en = 1'b0;
    #1;
    check("rst_run_off", 16'(cpu_run), 16'h0);
    next_cycle();
    check("rst_hold_ack", 16'(dma_ack), 16'h0);
    dma_req = 1'b0; run_en = 1'b1;
    next_cycle();
    reset = 1'b1;

    // Preload memory through the CPU write path
    next_cycle();
    cpu_addr = 16'h0200; cpu_wr = 2'b11; cpu_wdata = 16'hFFFF;
    #1;
    check("cpu_wr_pass", 16'(mem_wr), 16'h3);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      cpu_addr = 16'h0300 + 16'(i); cpu_wdata = 16'hA000 + 16'(i);
    end
    next_cycle();
    cpu_wr = 2'b00;

    // Idle DMA, CPU reads 0x3FFE every cycle
    cpu_addr = 16'h3FFE; cpu_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("idle_run", 16'(cpu_run), 16'h1);
      check("idle_addr", mem_addr, 16'h3FFE);
      check("idle_rd", 16'(mem_rd), 16'h1);
      check("idle_ack", 16'(dma_ack), 16'h0);
      next_cycle();
    end
    cpu_rd = 1'b0;

    // Single DMA write 0xBEEF to 0x0100, CPU read concurrently in request cycle
    cpu_addr = 16'h0020; cpu_rd = 1'b1;
    dma_req = 1'b1; dma_addr = 16'h0100; dma_we = 2'b11; dma_wdata = 16'hBEEF;
    #1;
    check("sw_req_ack", 16'(dma_ack), 16'h0);
    check("sw_req_cpuaddr", mem_addr, 16'h0020);
    check("sw_req_run", 16'(cpu_run), 16'h1);
    next_cycle();
    cpu_rd = 1'b0;
    #1;
    check("sw_ack", 16'(dma_ack), 16'h1);
    check("sw_mem_wr", 16'(mem_wr), 16'h3);
    check("sw_mem_rd", 16'(mem_rd), 16'h0);
    check("sw_addr", mem_addr, 16'h0100);
    check("sw_wdata", mem_wdata, 16'hBEEF);
    check("sw_run", 16'(cpu_run), 16'h0);
    next_cycle();
    dma_req = 1'b0;
    #1;
    check("sw_idle_ack", 16'(dma_ack), 16'h0);
    check("sw_idle_wr", 16'(mem_wr), 16'h0);
    check("sw_idle_rd", 16'(mem_rd), 16'h0);
    check("sw_idle_run", 16'(cpu_run), 16'h0);
    next_cycle();
    cpu_addr = 16'h0100; cpu_rd = 1'b1;
    #1;
    check("sw_back_run", 16'(cpu_run), 16'h1);
    check("sw_readback", cpu_rdata, 16'hBEEF);
    next_cycle();
    cpu_rd = 1'b0;

    // Byte write of low lane onto 0xFFFF
    dma_req = 1'b1; dma_addr = 16'h0200; dma_we = 2'b01; dma_wdata = 16'h12AB;
    next_cycle();
    #1;
    check("bw_ack", 16'(dma_ack), 16'h1);
    check("bw_wr", 16'(mem_wr), 16'h1);
    next_cycle();
    dma_req = 1'b0;
    next_cycle();
    cpu_addr = 16'h0200; cpu_rd = 1'b1;
    #1;
    check("bw_readback", cpu_rdata, 16'hFFAB);
    next_cycle();
    cpu_rd = 1'b0;

    // Burst of 10 reads with yielding enabled
    run_en = 1'b1; dma_we = 2'b00; acks = 0;
    dma_req = 1'b1; dma_addr = 16'h0300;
    #1;
    check("b1_req_ack", 16'(dma_ack), 16'h0);
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      dma_req = (acks < 10);
      dma_addr = 16'h0300 + 16'(acks);
      #1;
      check("b1_ack", 16'(dma_ack), 16'(exp_pat[i]));
      check("b1_run", 16'(cpu_run), 16'(!exp_pat[i]));
      if (exp_pat[i]) begin
        check("b1_rd", 16'(mem_rd), 16'h1);
        check("b1_rdata", dma_rdata, 16'hA000 + 16'(acks));
      end else begin
        check("b1_yield_rdata", dma_rdata, 16'h0000);
      end
      if (dma_ack) acks++;
    end
    check("b1_acks", 16'(acks), 16'd10);
    next_cycle();
    dma_req = 1'b0;
    #1;
    check("b1_tail_ack", 16'(dma_ack), 16'h0);
    check("b1_tail_rd", 16'(mem_rd), 16'h0);
    next_cycle();
    #1;
    check("b1_cpu_back", 16'(cpu_run), 16'h1);

    // Same burst with the CPU halted: no yield cycle
    run_en = 1'b0; acks = 0;
    dma_req = 1'b1; dma_addr = 16'h0300;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      dma_addr = 16'h0300 + 16'(acks);
      #1;
      check("b0_ack", 16'(dma_ack), 16'h1);
      check("b0_run", 16'(cpu_run), 16'h0);
      check("b0_rdata", dma_rdata, 16'hA000 + 16'(acks));
      if (dma_ack) acks++;
    end
    check("b0_acks", 16'(acks), 16'd10);
    next_cycle();
    dma_req = 1'b0;
    next_cycle();
    run_en = 1'b1;
    #1;
    check("b0_cpu_back", 16'(cpu_run), 16'h1);

    // Reset asserted during the third cycle of a DMA write burst
    dma_req = 1'b1; dma_addr = 16'h0400; dma_we = 2'b11; dma_wdata = 16'h5A5A;
    cpu_wr = 2'b00;
    next_cycle();
    #1;
    check("rb_ack1", 16'(dma_ack), 16'h1);
    next_cycle();
    #1;
    check("rb_ack2", 16'(dma_ack), 16'h1);
    next_cycle();
    #1;
    check("rb_ack3_pre", 16'(dma_ack), 16'h1);
    reset = 1'b0;
    #1;
    check("rb_rst_ack", 16'(dma_ack), 16'h0);
    check("rb_rst_wr", 16'(mem_wr), 16'h0);
    check("rb_rst_run", 16'(cpu_run), 16'h1);
    next_cycle();
    #1;
    check("rb_rst_hold", 16'(dma_ack), 16'h0);
    reset = 1'b1;
    #1;
    check("rb_rel_ack", 16'(dma_ack), 16'h0);
    next_cycle();
    #1;
    check("rb_first_ack", 16'(dma_ack), 16'h1);
    next_cycle();
    dma_req = 1'b0; dma_we = 2'b00;
    next_cycle();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
